dumbrv_mem_arbiter: RTL and testbench

Shares the single byte-wide external memory bus of the dumbrv core between the instruction-fetch unit and the load/store unit. Arbitrates between the two 32-bit request ports and serialises each winning access into a framed byte sequence on the bus: command, 3 address bytes, 4 data bytes. Sits between the core and the pin mux of the top-level `tt_um_dumbrv_yliu_hashed`.

---
 rtl/dumbrv_pkg.sv | 54 +++++
 rtl/dumbrv_arb2.sv | 41 ++++
 rtl/dumbrv_mem_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_dumbrv_mem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dumbrv_pkg.sv
// rtl/dumbrv_pkg.sv - shared types and bus-frame constants for the dumbrv memory arbiter
package dumbrv_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CMD,
        A2,
        A1,
        A0,
        D0,
        D1,
        D2,
        D3
    } state_t;

    localparam int CMD_WE_BIT  = 7;
    localparam int CMD_MASK_HI = 3;
    localparam int CMD_MASK_LO = 0;

    localparam int ADDR_BYTES = 3;
    localparam int DATA_BYTES = 4;
    localparam int BUS_ADDR_W = ADDR_BYTES * 8;
    localparam int WORD_W     = DATA_BYTES * 8;

    localparam int PORT_IF = 0;
    localparam int PORT_D  = 1;

    localparam logic [3:0] FETCH_MASK = 4'hF;

    function automatic logic [7:0] make_cmd(input logic we, input logic [3:0] mask);
        logic [7:0] c;
        c = 8'h00;
        c[CMD_WE_BIT] = we;
        c[CMD_MASK_HI:CMD_MASK_LO] = mask;
        return c;
    endfunction

    // Beat sequence of one frame; D3 wraps back to IDLE.
    function automatic state_t next_beat(input state_t s);
        state_t n;
        case (s)
            CMD:     n = A2;
            A2:      n = A1;
            A1:      n = A0;
            A0:      n = D0;
            D0:      n = D1;
            D1:      n = D2;
            D2:      n = D3;
            default: n = IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dumbrv_arb2.sv
// rtl/dumbrv_arb2.sv - two-way request arbiter; round-robin pointer under DUMBRV_RR_ARB_EN
module dumbrv_arb2
    import dumbrv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_gnt
);

`ifdef DUMBRV_RR_ARB_EN
    // r_last: 1 = data port won the most recent grant, 0 = fetch port.
    logic r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b0;
        end else if (i_advance && (|o_gnt)) begin
            r_last <= o_gnt[PORT_D];
        end
    end

    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11) begin
            o_gnt = r_last ? 2'b01 : 2'b10;
        end
    end
`else
    logic w_unused;
    assign w_unused = ^{clk, rst, i_advance};

    always_comb begin
        o_gnt          = 2'b00;
        o_gnt[PORT_D]  = i_req[PORT_D];
        o_gnt[PORT_IF] = i_req[PORT_IF] & ~i_req[PORT_D];
    end
`endif

endmodule

// File: rtl/dumbrv_mem_arbiter.sv
// rtl/dumbrv_mem_arbiter.sv - fetch/LSU arbiter serialising words onto a byte-wide framed bus; DUMBRV_RR_ARB_EN selects round-robin
module dumbrv_mem_arbiter
    import dumbrv_pkg::*;
#(
    parameter int ADDR_W = 24
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_wmask,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,

    output logic              bus_cs,
    output logic [7:0]        bus_out,
    output logic              bus_oe,
    input  logic [7:0]        bus_in,
    input  logic              bus_ready
);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [1:0]              w_arb_gnt;
    logic                    w_idle;
    logic                    w_grant;

    logic                    r_we;
    logic [3:0]              r_mask;
    logic [BUS_ADDR_W-1:0]   r_addr;
    logic [WORD_W-1:0]       r_wdata;
    logic                    r_owner_d;
    logic [WORD_W-9:0]       r_rbuf;
    logic [WORD_W-1:0]       w_rword;

    logic                    r_if_rvalid;
    logic                    r_d_rvalid;
    logic [WORD_W-1:0]       r_if_rdata;
    logic [WORD_W-1:0]       r_d_rdata;

    assign w_idle  = (r_state == IDLE);
    assign w_grant = w_idle && (|w_arb_gnt);
    assign w_rword = {bus_in, r_rbuf};

    dumbrv_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_req     ({d_req, if_req}),
        .i_advance (w_idle),
        .o_gnt     (w_arb_gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (|w_arb_gnt) begin
                    w_state_nxt = CMD;
                end
            end
            default: begin
                if (bus_ready) begin
                    w_state_nxt = next_beat(r_state);
                end
            end
        endcase
    end

    // Bus outputs decode purely from state and captured operands, so a stall holds them.
    always_comb begin
        bus_cs  = 1'b0;
        bus_oe  = 1'b0;
        bus_out = 8'h00;
        if_gnt  = 1'b0;
        d_gnt   = 1'b0;
        case (r_state)
            IDLE: begin
                if_gnt = w_arb_gnt[PORT_IF];
                d_gnt  = w_arb_gnt[PORT_D];
            end
            CMD: begin
                bus_cs  = 1'b1;
                bus_oe  = 1'b1;
                bus_out = make_cmd(r_we, r_mask);
            end
            A2: begin
                bus_cs  = 1'b1;
                bus_oe  = 1'b1;
                bus_out = r_addr[23:16];
            end
            A1: begin
                bus_cs  = 1'b1;
                bus_oe  = 1'b1;
                bus_out = r_addr[15:8];
            end
            A0: begin
                bus_cs  = 1'b1;
                bus_oe  = 1'b1;
                bus_out = r_addr[7:0];
            end
            D0: begin
                bus_cs  = 1'b1;
                bus_oe  = r_we;
                bus_out = r_we ? r_wdata[7:0] : 8'h00;
            end
            D1: begin
                bus_cs  = 1'b1;
                bus_oe  = r_we;
                bus_out = r_we ? r_wdata[15:8] : 8'h00;
            end
            D2: begin
                bus_cs  = 1'b1;
                bus_oe  = r_we;
                bus_out = r_we ? r_wdata[23:16] : 8'h00;
            end
            D3: begin
                bus_cs  = 1'b1;
                bus_oe  = r_we;
                bus_out = r_we ? r_wdata[31:24] : 8'h00;
            end
            default: begin
                bus_cs = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_mask      <= 4'h0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_owner_d   <= 1'b0;
            r_rbuf      <= '0;
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;

            if (w_grant) begin
                r_owner_d <= w_arb_gnt[PORT_D];
                if (w_arb_gnt[PORT_D]) begin
                    r_we    <= d_we;
                    r_mask  <= d_wmask;
                    r_addr  <= BUS_ADDR_W'(d_addr);
                    r_wdata <= d_wdata;
                end else begin
                    r_we    <= 1'b0;
                    r_mask  <= FETCH_MASK;
                    r_addr  <= BUS_ADDR_W'(if_addr);
                    r_wdata <= '0;
                end
            end

            // The last read byte bypasses r_rbuf straight into the port register.
            if (bus_ready && !r_we) begin
                case (r_state)
                    D0:      r_rbuf[7:0]   <= bus_in;
                    D1:      r_rbuf[15:8]  <= bus_in;
                    D2:      r_rbuf[23:16] <= bus_in;
                    default: ;
                endcase
            end

            if ((r_state == D3) && bus_ready) begin
                if (r_owner_d) begin
                    r_d_rvalid <= 1'b1;
                    r_d_rdata  <= r_we ? '0 : w_rword;
                end else begin
                    r_if_rvalid <= 1'b1;
                    r_if_rdata  <= w_rword;
                end
            end
        end
    end

    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign d_rvalid  = r_d_rvalid;
    assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_dumbrv_mem_arbiter.sv
// tb/tb_dumbrv_mem_arbiter.sv - table-driven scoreboard bench for dumbrv_mem_arbiter
module tb_dumbrv_mem_arbiter;

    typedef struct {
        bit          dport;
        bit          we;
        logic [23:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] mem;
        logic [7:0]  exp_cmd;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic [7:0] b;
        bit         oe;
        bit         chk;
        logic [7:0] din;
    } beat_t;

    typedef struct {
        bit          dport;
        logic [31:0] data;
    } rv_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [23:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [23:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wmask = '0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        bus_cs, bus_oe;
    logic [7:0]  bus_out;
    logic [7:0]  bus_in = 8'h00;
    logic        bus_ready = 1'b1;

    int    n_cmp = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    g_cyc = 0;
    int    rv_cyc [2];
    bit    mon_en = 1'b0;
    beat_t beat_q[$];
    rv_t   rv_q[$];
    vec_t  tbl[7];

    dumbrv_mem_arbiter #(.ADDR_W(24)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wmask   (d_wmask),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .bus_cs    (bus_cs),
        .bus_out   (bus_out),
        .bus_oe    (bus_oe),
        .bus_in    (bus_in),
        .bus_ready (bus_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Bus-side memory model and scoreboard: one expected beat per bus_cs cycle, popped on bus_ready.
    always @(negedge clk) begin
        beat_t bt;
        rv_t   r;
        if (mon_en && !rst) begin
            if (bus_cs) begin
                if (beat_q.size() == 0) begin
                    check("bus_cs_unexpected", bus_cs, 0);
                end else begin
                    bt = beat_q[0];
                    check("bus_oe", bus_oe, bt.oe);
                    if (bt.chk) check("bus_out", bus_out, bt.b);
                    bus_in = bt.din;
                    if (bus_ready) void'(beat_q.pop_front());
                end
            end else begin
                check("idle_bus_oe", bus_oe, 0);
                check("idle_bus_out", bus_out, 0);
            end
            if (if_rvalid || d_rvalid) begin
                if (if_rvalid) rv_cyc[0] = cyc;
                if (d_rvalid)  rv_cyc[1] = cyc;
                check("rvalid_onehot", if_rvalid & d_rvalid, 0);
                if (rv_q.size() == 0) begin
                    check("rvalid_unexpected", {if_rvalid, d_rvalid}, 0);
                end else begin
                    r = rv_q.pop_front();
                    check("rvalid_port", d_rvalid, r.dport);
                    check(r.dport ? "d_rdata" : "if_rdata", r.dport ? d_rdata : if_rdata, r.data);
                end
            end
        end
    end

    task automatic push_frame(input vec_t v);
        beat_t bt;
        rv_t   r;
        bt = '{b: v.exp_cmd, oe: 1'b1, chk: 1'b1, din: 8'h00};
        beat_q.push_back(bt);
        for (int i = 2; i >= 0; i--) begin
            bt = '{b: v.addr[8*i +: 8], oe: 1'b1, chk: 1'b1, din: 8'h00};
            beat_q.push_back(bt);
        end
        for (int i = 0; i < 4; i++) begin
            bt = '{b: v.wdata[8*i +: 8], oe: v.we, chk: v.we, din: v.mem[8*i +: 8]};
            beat_q.push_back(bt);
        end
        r = '{dport: v.dport, data: v.exp_rdata};
        rv_q.push_back(r);
    endtask

    // Raise one request, wait for its grant, drop it after the grant edge.
    task automatic start(input vec_t v);
        int n;
        n = 0;
        @(posedge clk); #1;
        if (v.dport) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_wmask = v.mask;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        push_frame(v);
        do begin
            @(negedge clk);
            n++;
        end while (!(v.dport ? d_gnt : if_gnt) && n < 20);
        check(v.dport ? "d_gnt" : "if_gnt", v.dport ? d_gnt : if_gnt, 1);
        check("other_gnt_low", v.dport ? if_gnt : d_gnt, 0);
        g_cyc = cyc;
        @(posedge clk); #1;
        if_req = 1'b0;
        d_req  = 1'b0;
    endtask

    task automatic wait_done(input bit dport, input int exp_lat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(dport ? d_rvalid : if_rvalid) && n < 40);
        check(dport ? "d_latency" : "if_latency", cyc - g_cyc, exp_lat);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vd, vf, v;
        logic [31:0] last_if, last_d;
        int prev, n, seen_rv;
        bit exp_d;

        //            dport we addr        wdata         mask  mem           cmd    rdata
        tbl[0] = '{1'b0, 1'b0, 24'h012345, 32'h00000000, 4'hF, 32'h44332211, 8'h0F, 32'h44332211};
        tbl[1] = '{1'b1, 1'b1, 24'h000010, 32'hDEADBEEF, 4'h3, 32'h00000000, 8'h83, 32'h00000000};
        tbl[2] = '{1'b1, 1'b0, 24'hABCDEF, 32'h00000000, 4'hF, 32'h89ABCDEF, 8'h0F, 32'h89ABCDEF};
        tbl[3] = '{1'b0, 1'b0, 24'hFFFFFF, 32'h00000000, 4'hF, 32'h00000000, 8'h0F, 32'h00000000};
        tbl[4] = '{1'b1, 1'b1, 24'hFFFFFE, 32'h00000000, 4'h0, 32'h5A5A5A5A, 8'h80, 32'h00000000};
        tbl[5] = '{1'b1, 1'b0, 24'h000000, 32'h00000000, 4'hF, 32'hFFFFFFFF, 8'h0F, 32'hFFFFFFFF};
        tbl[6] = '{1'b1, 1'b1, 24'h800000, 32'h12345678, 4'hC, 32'h00000000, 8'h8C, 32'h00000000};
        vd = '{1'b1, 1'b0, 24'h000100, 32'h0, 4'hF, 32'h01020304, 8'h0F, 32'h01020304};
        vf = '{1'b0, 1'b0, 24'h000200, 32'h0, 4'hF, 32'hA0B0C0D0, 8'h0F, 32'hA0B0C0D0};
        rv_cyc[0] = 0;
        rv_cyc[1] = 0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_bus_cs", bus_cs, 0);
        check("rst_bus_oe", bus_oe, 0);
        check("rst_bus_out", bus_out, 0);
        check("rst_gnt", {if_gnt, d_gnt}, 0);
        check("rst_rvalid", {if_rvalid, d_rvalid}, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        mon_en = 1'b1;

        last_if = 32'h0;
        last_d  = 32'h0;
        for (int i = 0; i < 7; i++) begin
            v = tbl[i];
            start(v);
            wait_done(v.dport, 9);
            if (v.dport) begin
                check("if_rdata_hold", if_rdata, last_if);
                last_d = v.exp_rdata;
            end else begin
                check("d_rdata_hold", d_rdata, last_d);
                last_if = v.exp_rdata;
            end
        end

        // Both requests held high continuously.
        pulse_reset();
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = vf.addr;
        d_req = 1'b1; d_we = vd.we; d_addr = vd.addr; d_wdata = vd.wdata; d_wmask = vd.mask;
        prev = 0;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(if_gnt || d_gnt) && n < 20);
`ifdef DUMBRV_RR_ARB_EN
            exp_d = (k % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            check("arb_winner_d", d_gnt, exp_d);
            check("arb_loser_if", if_gnt, !exp_d);
            push_frame(exp_d ? vd : vf);
            if (k > 0) check("arb_grant_spacing", cyc - prev, 9);
            prev = cyc;
            @(posedge clk); #1;
            if (k == 2) begin
                if_req = 1'b0;
                d_req  = 1'b0;
            end
        end
        repeat (10) @(negedge clk);

        // bus_ready low for 3 cycles while A1 is on the bus.
        start(vf);
        repeat (2) @(posedge clk);
        #1 bus_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus_ready = 1'b1;
        wait_done(1'b0, 12);

        // Reset asserted during D1 of a load.
        start(vd);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        beat_q.delete();
        rv_q.delete();
        @(negedge clk);
        check("midrst_bus_cs", bus_cs, 0);
        check("midrst_bus_oe", bus_oe, 0);
        seen_rv = 0;
        repeat (12) begin
            @(negedge clk);
            if (if_rvalid || d_rvalid) seen_rv++;
        end
        check("midrst_no_rvalid", seen_rv, 0);
        start(tbl[0]);
        wait_done(1'b0, 9);

        // Fetch raised in the cycle d_rvalid pulses is granted that same cycle.
        start(vd);
        prev = g_cyc;
        repeat (7) @(posedge clk);
        start(vf);
        check("b2b_grant_cycle", g_cyc - prev, 9);
        check("b2b_d_rvalid_cycle", rv_cyc[1] - prev, 9);
        wait_done(1'b0, 9);

        repeat (3) @(negedge clk);
        check("beats_outstanding", beat_q.size(), 0);
        check("rvalid_outstanding", rv_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
